// File: rtl/spi_reg_pkg.sv
// Shared types and constants for the SPI register-access controller.
// Holds the FSM encoding, command-byte layout and the fabric register map.
package spi_reg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CMD     = 3'd1,
        ST_WDATA   = 3'd2,
        ST_RD_ISS  = 3'd3,
        ST_RD_WAIT = 3'd4,
        ST_RDATA   = 3'd5
    } state_e;

    localparam int         CMD_RW_BIT    = 7;
    localparam logic [7:0] IDLE_BYTE_DEF = 8'h5A;

    localparam logic [6:0] REG_LED     = 7'h00;
    localparam logic [6:0] REG_SCRATCH = 7'h01;
    localparam logic [6:0] REG_STATUS  = 7'h02;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for a single asynchronous level.
// RESET_VAL sets the inactive level presented while in reset.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic meta_r;
    logic sync_r;

    // Two-stage capture of the asynchronous input
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            meta_r <= RESET_VAL;
            sync_r <= RESET_VAL;
        end else begin
            meta_r <= i_d;
            sync_r <= meta_r;
        end
    end

    assign o_q = sync_r;

endmodule

// File: rtl/spi_reg_ctrl.sv
// Turns spi_target byte traffic into register accesses: command byte {RW, ADDR}
// followed by data bytes with auto-incrementing address; reads are prefetched.
module spi_reg_ctrl
    import spi_reg_pkg::*;
#(
    parameter int         ADDR_W    = 7,
    parameter logic [7:0] IDLE_BYTE = IDLE_BYTE_DEF,
    parameter int         RD_LAT    = 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_ss_n,
    input  logic [7:0]        i_rx_data,
    input  logic              i_rx_valid,
    output logic [7:0]        o_tx_data,
    output logic [ADDR_W-1:0] o_bus_addr,
    output logic              o_bus_wr,
    output logic [7:0]        o_bus_wdata,
    output logic              o_bus_rd,
    input  logic [7:0]        i_bus_rdata,
    output logic              o_busy,
    output logic              o_err
);

    localparam logic [1:0] RD_LAT_L = 2'(RD_LAT);

    logic              ss_s;
    logic              ss_prev_r;
    logic              ss_rise_s;
    state_e            state_r;
    state_e            state_nxt_s;
    logic [ADDR_W-1:0] addr_r;
    logic [1:0]        lat_cnt_r;

    sync_2ff #(.RESET_VAL(1'b1)) u_ss_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (i_ss_n),
        .o_q     (ss_s)
    );

    assign ss_rise_s = ss_s & ~ss_prev_r;

    // Next-state selection; frame end overrides everything
    always_comb begin
        state_nxt_s = state_r;
        if (ss_rise_s) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (!ss_s) state_nxt_s = ST_CMD;
                    else       state_nxt_s = ST_IDLE;
                end
                ST_CMD: begin
                    if (i_rx_valid) state_nxt_s = i_rx_data[CMD_RW_BIT] ? ST_RD_ISS : ST_WDATA;
                    else            state_nxt_s = ST_CMD;
                end
                ST_WDATA:  state_nxt_s = ST_WDATA;
                ST_RD_ISS: state_nxt_s = ST_RD_WAIT;
                ST_RD_WAIT: begin
                    if (lat_cnt_r == RD_LAT_L) state_nxt_s = ST_RDATA;
                    else                       state_nxt_s = ST_RD_WAIT;
                end
                ST_RDATA: begin
                    if (i_rx_valid) state_nxt_s = ST_RD_ISS;
                    else            state_nxt_s = ST_RDATA;
                end
                default: state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // State, address counter, latency counter and all registered outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r     <= ST_IDLE;
            ss_prev_r   <= 1'b1;
            addr_r      <= '0;
            lat_cnt_r   <= 2'd0;
            o_tx_data   <= IDLE_BYTE;
            o_bus_addr  <= '0;
            o_bus_wr    <= 1'b0;
            o_bus_wdata <= 8'h00;
            o_bus_rd    <= 1'b0;
            o_busy      <= 1'b0;
            o_err       <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            ss_prev_r <= ss_s;
            o_busy    <= ~ss_s;
            o_bus_wr  <= 1'b0;
            o_bus_rd  <= 1'b0;
            if (ss_rise_s) begin
                o_tx_data <= IDLE_BYTE;
                if ((state_r == ST_RD_ISS) || (state_r == ST_RD_WAIT)) o_err <= 1'b1;
            end else begin
                case (state_r)
                    ST_CMD: begin
                        if (i_rx_valid) addr_r <= i_rx_data[ADDR_W-1:0];
                    end
                    ST_WDATA: begin
                        if (i_rx_valid) begin
                            o_bus_wr    <= 1'b1;
                            o_bus_wdata <= i_rx_data;
                            o_bus_addr  <= addr_r;
                            addr_r      <= addr_r + ADDR_W'(1);
                        end
                    end
                    ST_RD_ISS: begin
                        o_bus_rd   <= 1'b1;
                        o_bus_addr <= addr_r;
                        lat_cnt_r  <= 2'd0;
                        if (i_rx_valid) o_err <= 1'b1;
                    end
                    ST_RD_WAIT: begin
                        // A byte landing here is lost; the fetch still completes
                        if (i_rx_valid) o_err <= 1'b1;
                        if (lat_cnt_r == RD_LAT_L) begin
                            o_tx_data <= i_bus_rdata;
                            addr_r    <= addr_r + ADDR_W'(1);
                        end else begin
                            lat_cnt_r <= lat_cnt_r + 2'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Directed bench for spi_reg_ctrl: byte-level stand-in for spi_target (SCK = clk/10)
// plus a 128-entry register model with 3-clock read latency.
module tb_spi_reg_ctrl;
    import spi_reg_pkg::*;

    localparam int LAT = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ss_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic [6:0] bus_addr;
    logic       bus_wr;
    logic [7:0] bus_wdata;
    logic       bus_rd;
    logic [7:0] bus_rdata = 8'hEE;
    logic       busy;
    logic       err;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [0:127];
    logic [7:0] rp1 = 8'hEE;
    logic [7:0] rp2 = 8'hEE;
    int         wr_cnt = 0;
    int         rd_cnt = 0;
    int         both_cnt = 0;
    logic [6:0] wr_addr [0:63];
    logic [7:0] wr_data [0:63];
    logic [6:0] rd_addr [0:63];

    spi_reg_ctrl #(.ADDR_W(7), .IDLE_BYTE(8'h5A), .RD_LAT(LAT)) u_dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_ss_n      (ss_n),
        .i_rx_data   (rx_data),
        .i_rx_valid  (rx_valid),
        .o_tx_data   (tx_data),
        .o_bus_addr  (bus_addr),
        .o_bus_wr    (bus_wr),
        .o_bus_wdata (bus_wdata),
        .o_bus_rd    (bus_rd),
        .i_bus_rdata (bus_rdata),
        .o_busy      (busy),
        .o_err       (err)
    );

    always #10 clk = ~clk;

    // Register model: logs strobes, read data valid for exactly one clock
    always @(posedge clk) begin
        rp1       <= bus_rd ? mem[bus_addr] : 8'hEE;
        rp2       <= rp1;
        bus_rdata <= rp2;
        if (bus_wr) begin
            mem[bus_addr] <= bus_wdata;
            if (wr_cnt < 64) begin
                wr_addr[wr_cnt] <= bus_addr;
                wr_data[wr_cnt] <= bus_wdata;
            end
            wr_cnt <= wr_cnt + 1;
        end
        if (bus_rd) begin
            if (rd_cnt < 64) rd_addr[rd_cnt] <= bus_addr;
            rd_cnt <= rd_cnt + 1;
        end
        if (bus_wr && bus_rd) both_cnt <= both_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic frame_begin();
        @(posedge clk);
        #1 ss_n = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    task automatic frame_end();
        repeat (10) @(posedge clk);
        #1 ss_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
    endtask

    // MISO for a slot is whatever o_tx_data holds when the slot starts shifting
    task automatic send_byte(input logic [7:0] b, input int lead, input int tail, output logic [7:0] miso);
        repeat (lead) @(posedge clk);
        #1 miso = tx_data;
        repeat (tail) @(posedge clk);
        #1;
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1 rx_valid = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, output logic [7:0] miso);
        send_byte(b, 8, 72, miso);
    endtask

    initial begin
        logic [7:0] m0, m1, m2;
        int w0, r0;
        rst_n = 1'b0; ss_n = 1'b1; rx_data = 8'h00; rx_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_tx", 32'(tx_data), 32'h5A);
        check_eq("rst_wr", 32'(bus_wr), 32'h0);
        check_eq("rst_rd", 32'(bus_rd), 32'h0);
        check_eq("rst_addr", 32'(bus_addr), 32'h0);
        check_eq("rst_busy", 32'(busy), 32'h0);
        check_eq("rst_err", 32'(err), 32'h0);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);

        // Write burst to scratch then status
        w0 = wr_cnt;
        frame_begin();
        send({1'b0, REG_SCRATCH}, m0);
        send(8'hAB, m1);
        send(8'hCD, m2);
        check_eq("wr_busy_in_frame", 32'(busy), 32'h1);
        frame_end();
        check_eq("wr_miso0", 32'(m0), 32'h5A);
        check_eq("wr_count", 32'(wr_cnt - w0), 32'd2);
        check_eq("wr_a0", 32'(wr_addr[w0]), 32'h01);
        check_eq("wr_d0", 32'(wr_data[w0]), 32'hAB);
        check_eq("wr_a1", 32'(wr_addr[w0 + 1]), 32'h02);
        check_eq("wr_d1", 32'(wr_data[w0 + 1]), 32'hCD);
        check_eq("wr_busy_after", 32'(busy), 32'h0);

        // Preload reg2/reg3, then read burst with latency check
        frame_begin();
        send({1'b0, REG_STATUS}, m0);
        send(8'h33, m0);
        send(8'h44, m0);
        frame_end();
        r0 = rd_cnt;
        frame_begin();
        send(8'h82, m0);
        repeat (4) @(posedge clk);
        #1 check_eq("rd_lat_early", 32'(tx_data), 32'h5A);
        @(posedge clk);
        #1 check_eq("rd_lat_on_time", 32'(tx_data), 32'h33);
        send(8'h00, m1);
        send(8'h00, m2);
        frame_end();
        check_eq("rd_miso0", 32'(m0), 32'h5A);
        check_eq("rd_miso1", 32'(m1), 32'h33);
        check_eq("rd_miso2", 32'(m2), 32'h44);
        check_eq("rd_count", 32'(rd_cnt - r0), 32'd3);
        check_eq("rd_first_addr", 32'(rd_addr[r0]), 32'h02);
        check_eq("rd_prefetch_addr", 32'(rd_addr[r0 + 2]), 32'h04);
        check_eq("rd_no_err", 32'(err), 32'h0);
        check_eq("rd_tx_idle_after", 32'(tx_data), 32'h5A);

        // Address wrap
        w0 = wr_cnt;
        frame_begin();
        send(8'h7F, m0);
        send(8'h11, m0);
        send(8'h22, m0);
        frame_end();
        check_eq("wrap_count", 32'(wr_cnt - w0), 32'd2);
        check_eq("wrap_a0", 32'(wr_addr[w0]), 32'h7F);
        check_eq("wrap_a1", 32'(wr_addr[w0 + 1]), 32'h00);
        check_eq("wrap_d1", 32'(wr_data[w0 + 1]), 32'h22);

        // Abort after 3 bits of the first data byte
        w0 = wr_cnt;
        frame_begin();
        send(8'h00, m0);
        repeat (38) @(posedge clk);
        #1 ss_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("abort_busy_3clk", 32'(busy), 32'h0);
        check_eq("abort_tx", 32'(tx_data), 32'h5A);
        repeat (4) @(posedge clk);
        check_eq("abort_no_wr", 32'(wr_cnt - w0), 32'd0);
        frame_begin();
        send({1'b0, REG_LED}, m0);
        send(8'h01, m0);
        frame_end();
        check_eq("post_abort_count", 32'(wr_cnt - w0), 32'd1);
        check_eq("post_abort_a", 32'(wr_addr[w0]), 32'h00);
        check_eq("post_abort_d", 32'(wr_data[w0]), 32'h01);

        // Byte on the same clock as the detected frame end is discarded
        w0 = wr_cnt;
        frame_begin();
        send(8'h05, m0);
        repeat (20) @(posedge clk);
        #1 ss_n = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rx_data  = 8'h99;
        rx_valid = 1'b1;
        @(posedge clk);
        #1 rx_valid = 1'b0;
        repeat (4) @(posedge clk);
        check_eq("end_wins_no_wr", 32'(wr_cnt - w0), 32'd0);

        // Byte arriving during a read fetch sets sticky error
        frame_begin();
        send(8'h82, m0);
        send_byte(8'h00, 1, 1, m1);
        repeat (3) @(posedge clk);
        #1 check_eq("err_set", 32'(err), 32'h1);
        send(8'h00, m1);
        frame_end();
        check_eq("err_sticky", 32'(err), 32'h1);
        frame_begin();
        send(8'h83, m0);
        send(8'h00, m1);
        frame_end();
        check_eq("err_next_frame_data", 32'(m1), 32'h44);
        check_eq("err_still_set", 32'(err), 32'h1);

        // Reset in the middle of a read burst, while a read strobe is out
        frame_begin();
        send(8'h82, m0);
        send(8'h00, m1);
        @(posedge clk);
        #1 check_eq("midrd_strobe_pre", 32'(bus_rd), 32'h1);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_rd", 32'(bus_rd), 32'h0);
        check_eq("midrst_tx", 32'(tx_data), 32'h5A);
        check_eq("midrst_busy", 32'(busy), 32'h0);
        check_eq("midrst_err", 32'(err), 32'h0);
        check_eq("midrst_addr", 32'(bus_addr), 32'h0);
        ss_n = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        frame_begin();
        send(8'h81, m0);
        send(8'h00, m1);
        frame_end();
        check_eq("postrst_miso0", 32'(m0), 32'h5A);
        check_eq("postrst_miso1", 32'(m1), 32'hAB);
        check_eq("postrst_err", 32'(err), 32'h0);

        check_eq("wr_rd_overlap", 32'(both_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
